// File: rtl/cachewb_pkg.sv
// cachewb_pkg: shared types and default geometry for the victim writeback slice.
//   state_t      - writeback FSM states
//   *_DEF        - default cache/bus geometry
//   BEATS, BEATCNTLEN, LOGNUMWAYS - derived from the default geometry
package cachewb_pkg;

    localparam int unsigned NUMWAYS_DEF   = 4;
    localparam int unsigned SETLEN_DEF    = 7;
    localparam int unsigned OFFSETLEN_DEF = 6;
    localparam int unsigned TAGLEN_DEF    = 43;
    localparam int unsigned LINELEN_DEF   = 512;
    localparam int unsigned BEATLEN_DEF   = 64;

    localparam int unsigned BEATS      = LINELEN_DEF / BEATLEN_DEF;
    localparam int unsigned BEATCNTLEN = $clog2(BEATS);
    localparam int unsigned LOGNUMWAYS = $clog2(NUMWAYS_DEF);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADR  = 3'd1,
        DATA = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/binencoder.sv
// binencoder: one-hot to binary index encoder.
//   i_onehot [N]     one-hot input (multi-hot gives an undefined index)
//   o_idx    [W]     binary index of the set bit; 0 when no bit is set
module binencoder #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] i_onehot,
    output logic [W-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_onehot[i]) begin
                o_idx = o_idx | i[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cachewb_linebuf.sv
// cachewb_linebuf: capture register for the victim tag, set and line, plus the
// beat selector that feeds the bus data channel.
//   clk          clock
//   i_en         capture enable
//   i_tag/i_set/i_line   victim fields to capture
//   i_beat_idx   beat number to present (beat 0 = least significant bits)
//   o_tag/o_set  captured tag and set
//   o_beat       selected beat of the captured line
module cachewb_linebuf #(
    parameter int unsigned TAGLEN  = 43,
    parameter int unsigned SETLEN  = 7,
    parameter int unsigned LINELEN = 512,
    parameter int unsigned BEATLEN = 64,
    parameter int unsigned CNTLEN  = $clog2(LINELEN / BEATLEN)
) (
    input  logic               clk,
    input  logic               i_en,
    input  logic [TAGLEN-1:0]  i_tag,
    input  logic [SETLEN-1:0]  i_set,
    input  logic [LINELEN-1:0] i_line,
    input  logic [CNTLEN-1:0]  i_beat_idx,
    output logic [TAGLEN-1:0]  o_tag,
    output logic [SETLEN-1:0]  o_set,
    output logic [BEATLEN-1:0] o_beat
);

    logic [TAGLEN-1:0]  r_tag;
    logic [SETLEN-1:0]  r_set;
    logic [LINELEN-1:0] r_line;

    // Contents are don't-care after reset, so no reset term is needed.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_tag  <= i_tag;
            r_set  <= i_set;
            r_line <= i_line;
        end
    end

    assign o_tag  = r_tag;
    assign o_set  = r_set;
    assign o_beat = r_line[i_beat_idx*BEATLEN +: BEATLEN];

endmodule

// File: rtl/cache_victim_writeback.sv
// cache_victim_writeback: captures the victim line chosen by replacement and,
// when dirty, drains it to memory as address phase, BEATS data beats and a
// write response. Clean victims complete without bus traffic.
//   clk, reset_n                     clock, async active-low reset
//   EvictReq/EvictReady              eviction request handshake
//   VictimWay/Dirty/Tag/Set/Line     victim description
//   BusAdrValid/Ready, BusAdr        address phase
//   BusDataValid/Ready, BusData, BusDataLast   data beats
//   BusRespValid, BusRespErr         write response
//   EvictDone, EvictErr, EvictWayEnc completion pulse and status
module cache_victim_writeback
    import cachewb_pkg::*;
#(
    parameter int unsigned NUMWAYS   = NUMWAYS_DEF,
    parameter int unsigned SETLEN    = SETLEN_DEF,
    parameter int unsigned OFFSETLEN = OFFSETLEN_DEF,
    parameter int unsigned TAGLEN    = TAGLEN_DEF,
    parameter int unsigned LINELEN   = LINELEN_DEF,
    parameter int unsigned BEATLEN   = BEATLEN_DEF
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                EvictReq,
    output logic                                EvictReady,
    input  logic [NUMWAYS-1:0]                  VictimWay,
    input  logic                                VictimDirty,
    input  logic [TAGLEN-1:0]                   VictimTag,
    input  logic [SETLEN-1:0]                   VictimSet,
    input  logic [LINELEN-1:0]                  VictimLine,
    output logic                                BusAdrValid,
    input  logic                                BusAdrReady,
    output logic [TAGLEN+SETLEN+OFFSETLEN-1:0]  BusAdr,
    output logic                                BusDataValid,
    input  logic                                BusDataReady,
    output logic [BEATLEN-1:0]                  BusData,
    output logic                                BusDataLast,
    input  logic                                BusRespValid,
    input  logic                                BusRespErr,
    output logic                                EvictDone,
    output logic                                EvictErr,
    output logic [$clog2(NUMWAYS)-1:0]          EvictWayEnc
);

    localparam int unsigned L_BEATS   = LINELEN / BEATLEN;
    localparam int unsigned L_CNTLEN  = $clog2(L_BEATS);
    localparam int unsigned L_WAYLEN  = $clog2(NUMWAYS);
    localparam logic [L_CNTLEN-1:0]  LAST_BEAT = L_CNTLEN'(L_BEATS - 1);
    localparam logic [OFFSETLEN-1:0] OFS_ZERO  = '0;

    state_t               r_state;
    logic [L_CNTLEN-1:0]  r_cnt;
    logic                 r_err;
    logic [L_WAYLEN-1:0]  r_way_enc;

    logic                 w_accept;
    logic [L_WAYLEN-1:0]  w_way_enc;
    logic [TAGLEN-1:0]    w_tag;
    logic [SETLEN-1:0]    w_set;
    logic [BEATLEN-1:0]   w_beat;

    assign w_accept = EvictReq && (r_state == IDLE);

    binencoder #(
        .N (NUMWAYS),
        .W (L_WAYLEN)
    ) u_enc (
        .i_onehot (VictimWay),
        .o_idx    (w_way_enc)
    );

    cachewb_linebuf #(
        .TAGLEN  (TAGLEN),
        .SETLEN  (SETLEN),
        .LINELEN (LINELEN),
        .BEATLEN (BEATLEN),
        .CNTLEN  (L_CNTLEN)
    ) u_linebuf (
        .clk        (clk),
        .i_en       (w_accept),
        .i_tag      (VictimTag),
        .i_set      (VictimSet),
        .i_line     (VictimLine),
        .i_beat_idx (r_cnt),
        .o_tag      (w_tag),
        .o_set      (w_set),
        .o_beat     (w_beat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_way_enc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (EvictReq) begin
                        r_way_enc <= w_way_enc;
                        r_err     <= 1'b0;
                        // A zero way vector has nothing to write back.
                        r_state   <= (VictimDirty && (|VictimWay)) ? ADR : DONE;
                    end
                end
                ADR: begin
                    if (BusAdrReady) begin
                        r_cnt   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (BusDataReady) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt   <= '0;
                            r_state <= RESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (BusRespValid) begin
                        r_err   <= BusRespErr;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Payload outputs are forced to zero outside their phase so the bus sees
    // no stale buffer contents after reset or between evictions.
    assign EvictReady   = (r_state == IDLE);
    assign BusAdrValid  = (r_state == ADR);
    assign BusAdr       = BusAdrValid ? {w_tag, w_set, OFS_ZERO} : '0;
    assign BusDataValid = (r_state == DATA);
    assign BusData      = BusDataValid ? w_beat : '0;
    assign BusDataLast  = BusDataValid && (r_cnt == LAST_BEAT);
    assign EvictDone    = (r_state == DONE);
    assign EvictErr     = EvictDone && r_err;
    assign EvictWayEnc  = EvictDone ? r_way_enc : '0;

endmodule
